// File: rtl/odd_seq_pkg.sv
// Shared types and helpers for the odd-sequence counter checker.
package odd_seq_pkg;

    localparam int unsigned WIDTH_DEF     = 8;
    localparam int unsigned LOCK_CNT_DEF  = 3;
    localparam int unsigned ERR_CNT_W_DEF = 8;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} chk_state_e;

    // Successor of x in the odd sequence, truncated to w bits (all-ones maps to itself).
    function automatic logic [63:0] next_odd(input logic [63:0] x, input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((x << 1) | 64'd1) & mask;
    endfunction

    // True when x has the form 2^k-1 (zero-extended input).
    function automatic logic is_therm(input logic [63:0] x);
        return (x & (x + 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/odd_seq_checker_if.sv
// Link between the odd-sequence counter producer and its receive-side checker.
interface odd_seq_checker_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CNT_W = 8
) ();
    localparam int unsigned STEP_W = $clog2(WIDTH + 1);

    logic                 valid_i;
    logic [WIDTH-1:0]     data_i;
    logic                 locked_o;
    logic [STEP_W-1:0]    step_o;
    logic                 err_o;
    logic                 sat_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output valid_i, data_i,
        input  locked_o, step_o, err_o, sat_o, err_cnt_o
    );

    modport slave (
        input  valid_i, data_i,
        output locked_o, step_o, err_o, sat_o, err_cnt_o
    );
endinterface

// File: rtl/odd_seq_step_enc.sv
// Thermometer-to-count encoder: number of ones in a legal counter word.
module odd_seq_step_enc #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]  therm_i,
    output logic [STEP_W-1:0] step_c
);
    always_comb begin
        step_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            step_c = step_c + STEP_W'(therm_i[i]);
        end
    end
endmodule

// File: rtl/odd_seq_checker.sv
// Receive-side lock/error checker for the odd-sequence counter stream.
// Define ODD_CHK_ERRCNT_EN to build the saturating error counter; otherwise err_cnt_o is 0.
module odd_seq_checker
    import odd_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF,
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    odd_seq_checker_if.slave bus
);
    localparam int unsigned STEP_W = $clog2(WIDTH + 1);

    chk_state_e        state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [3:0]        match_q, match_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              sat_q, sat_d;
    logic              err_q, err_d;
    logic              locked_q, locked_d;

    logic [STEP_W-1:0] step_enc;
    logic              legal;
    logic [WIDTH-1:0]  exp_val;
    logic [3:0]        match_inc;

    odd_seq_step_enc #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_step_enc (
        .therm_i (bus.data_i),
        .step_c  (step_enc)
    );

    assign legal     = is_therm(64'(bus.data_i));
    assign exp_val   = WIDTH'(next_odd(64'(prev_q), WIDTH));
    assign match_inc = match_q + 4'd1;

    // Next-state and sample bookkeeping
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        match_d = match_q;
        step_d  = step_q;
        sat_d   = sat_q;
        err_d   = 1'b0;

        if (bus.valid_i) begin
            if (legal) begin
                step_d = step_enc;
                sat_d  = &bus.data_i;
            end
            case (state_q)
                HUNT: begin
                    if (legal) begin
                        state_d = SYNC;
                        prev_d  = bus.data_i;
                        match_d = 4'd0;
                    end
                end
                SYNC: begin
                    if (bus.data_i == exp_val) begin
                        prev_d = bus.data_i;
                        if (match_inc >= 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            match_d = 4'd0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else if (legal) begin
                        prev_d  = bus.data_i;
                        match_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (bus.data_i == exp_val) begin
                        prev_d = bus.data_i;
                    end else if (bus.data_i == '0) begin
                        // Counter restart is not an error.
                        state_d = SYNC;
                        prev_d  = '0;
                        match_d = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        prev_d  = bus.data_i;
                        match_d = 4'd0;
                        state_d = legal ? SYNC : HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            match_q  <= 4'd0;
            step_q   <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            step_q   <= step_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign bus.locked_o = locked_q;
    assign bus.step_o   = step_q;
    assign bus.err_o    = err_q;
    assign bus.sat_o    = sat_q;

`ifdef ODD_CHK_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating error counter, never wraps.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed self-checking bench for odd_seq_checker (WIDTH=8, LOCK_CNT=3, ERR_CNT_W=8).
module tb_odd_seq_checker;

`ifdef ODD_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   n_err;

    odd_seq_checker_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();

    odd_seq_checker #(.WIDTH(8), .LOCK_CNT(3), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_cnt(input int n);
        if (!CNT_EN) return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one valid sample; returns #1 after the capturing edge.
    task automatic send(input logic [7:0] d);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic [3:0] st,
                           input logic er, input logic sa, input int ne);
        chk({tag, "_locked"}, 32'(bus.locked_o), 32'(lk));
        chk({tag, "_step"},   32'(bus.step_o),   32'(st));
        chk({tag, "_err"},    32'(bus.err_o),    32'(er));
        chk({tag, "_sat"},    32'(bus.sat_o),    32'(sa));
        chk({tag, "_cnt"},    32'(bus.err_cnt_o), exp_cnt(ne));
    endtask

    initial begin
        logic [7:0] run [7];
        n_assert    = 0;
        n_fail      = 0;
        n_err       = 0;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'd0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'd0, 1'b0, 1'b0, 0);
        reset = 1'b0;

        // Acquire lock on 0,1,3,7
        send(8'd0);  chk_all("acq0", 1'b0, 4'd0, 1'b0, 1'b0, 0);
        send(8'd1);  chk("acq1_locked", 32'(bus.locked_o), 32'd0);
        send(8'd3);  chk("acq3_locked", 32'(bus.locked_o), 32'd0);
        send(8'd7);  chk_all("acq7", 1'b1, 4'd3, 1'b0, 1'b0, 0);

        // Locked run up to and through saturation
        run = '{8'd15, 8'd31, 8'd63, 8'd127, 8'd255, 8'd255, 8'd255};
        for (int i = 0; i < 7; i++) begin
            send(run[i]);
            chk_all($sformatf("run%0d", i), 1'b1, (i < 4) ? 4'(i + 4) : 4'd8,
                    1'b0, (run[i] == 8'd255), 0);
        end

        // Restart at 0 from saturation, then relock
        send(8'd0);  chk_all("rst0", 1'b0, 4'd0, 1'b0, 1'b0, 0);
        send(8'd1);
        send(8'd3);
        send(8'd7);  chk_all("relock", 1'b1, 4'd3, 1'b0, 1'b0, 0);

        // Idle gaps while locked
        send(8'd15);
        idle(4);     chk("idle_locked", 32'(bus.locked_o), 32'd1);
        send(8'd31); chk_all("gap31", 1'b1, 4'd5, 1'b0, 1'b0, 0);

        // Restart at 63 -> 0, relock, counter unchanged
        send(8'd63);
        send(8'd0);  chk_all("r63_0", 1'b0, 4'd0, 1'b0, 1'b0, 0);
        send(8'd1);
        send(8'd3);
        send(8'd7);  chk_all("r63_relock", 1'b1, 4'd3, 1'b0, 1'b0, 0);

        // Illegal value while locked at 7
        send(8'd5);  n_err++;
        chk_all("bad5", 1'b0, 4'd3, 1'b1, 1'b0, n_err);
        idle(1);     chk("bad5_pulse", 32'(bus.err_o), 32'd0);
        // From HUNT: 1 seeds, then 3,7,15 are the three correct steps
        send(8'd1);
        send(8'd3);
        send(8'd7);  chk("hunt_nolock", 32'(bus.locked_o), 32'd0);
        send(8'd15); chk_all("hunt_lock", 1'b1, 4'd4, 1'b0, 1'b0, n_err);

        // Legal but wrong value while locked: error and reseed in SYNC
        send(8'd3);  n_err++;
        chk_all("bad3", 1'b0, 4'd2, 1'b1, 1'b0, n_err);
        send(8'd7);
        send(8'd15); chk("sync_nolock", 32'(bus.locked_o), 32'd0);
        send(8'd31); chk("sync_lock", 32'(bus.locked_o), 32'd1);

        // Illegal sample in SYNC returns to HUNT without error
        send(8'd0);
        send(8'd6);  chk("sync_ill_err", 32'(bus.err_o), 32'd0);
        send(8'd1);
        send(8'd3);
        send(8'd7);  chk("sync_ill_nolock", 32'(bus.locked_o), 32'd0);

        // Drive enough errors to saturate the error counter
        for (int i = 0; i < 300; i++) begin
            send(8'd0);
            send(8'd1);
            send(8'd3);
            send(8'd7);
            send(8'd5);
            n_err++;
        end
        chk_all("sat_cnt", 1'b0, 4'd3, 1'b1, 1'b0, n_err);

        // Reset asserted mid-stream with a valid sample present
        send(8'd0);
        send(8'd1);
        send(8'd3);
        send(8'd7);
        send(8'd255);
        bus.valid_i = 1'b1;
        bus.data_i  = 8'd255;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        chk_all("mid_reset", 1'b0, 4'd0, 1'b0, 1'b0, 0);
        reset       = 1'b0;
        bus.valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
